baud_rate_gen: RTL and testbench

//  Parametrised UART baud/oversample clock generator. Successor to the fixed 16x9600 divider.

---
 rtl/baud_pkg.sv | 13 +
 rtl/baud_rate_gen_if.sv | 29 ++
 rtl/baud_prescaler.sv | 87 ++++++++
 rtl/baud_rate_gen.sv | 68 ++++++
 tb/tb_baud_rate_gen.sv | 348 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/baud_pkg.sv
// Shared defaults and helpers for the UART baud/oversample clock generator.
package baud_pkg;

   localparam int BAUD_DIV_W       = 10;
   localparam int BAUD_DEFAULT_DIV = 163;
   localparam int BAUD_OVERSAMPLE  = 16;

   // A zero half-period would stall the counter, so it is promoted to 1.
   function automatic logic [31:0] sat_div(input logic [31:0] div);
      return (div == 32'd0) ? 32'd1 : div;
   endfunction

endpackage

// File: rtl/baud_rate_gen_if.sv
// Control and tick bundle between the baud generator and its UART clients.
interface baud_rate_gen_if
   import baud_pkg::*;
#(
   parameter int DIV_W      = BAUD_DIV_W,
   parameter int OVERSAMPLE = BAUD_OVERSAMPLE
);
   localparam int PH_W = $clog2(OVERSAMPLE);

   logic             en;
   logic [DIV_W-1:0] div_i;
   logic             div_load;
   logic             resync;
   logic             clk_out;
   logic             tick_os;
   logic             tick_bit;
   logic [PH_W-1:0]  os_phase;

   modport master (
      output en, div_i, div_load, resync,
      input  clk_out, tick_os, tick_bit, os_phase
   );

   modport slave (
      input  en, div_i, div_load, resync,
      output clk_out, tick_os, tick_bit, os_phase
   );

endinterface

// File: rtl/baud_prescaler.sv
// Half-period counter with shadowed divisor; drives the 50%-duty clock and
// a one-cycle strobe on every rising toggle.
module baud_prescaler
   import baud_pkg::*;
#(
   parameter int DIV_W       = BAUD_DIV_W,
   parameter int DEFAULT_DIV = BAUD_DEFAULT_DIV
) (
   input  logic             sysclk,
   input  logic             reset,
   input  logic             en,
   input  logic [DIV_W-1:0] div_i,
   input  logic             div_load,
   input  logic             resync,
   output logic             clk_out,
   output logic             rise
);

   localparam logic [DIV_W-1:0] DIV_RST = DIV_W'(DEFAULT_DIV);
   localparam logic [DIV_W-1:0] CNT_ONE = DIV_W'(1);

   logic [DIV_W-1:0] cnt_q, cnt_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic [DIV_W-1:0] div_n_q, div_n_d;
   logic             pend_q, pend_d;
   logic             clk_q, clk_d;
   logic [DIV_W-1:0] div_sat;
   logic             wrap;

   assign div_sat = DIV_W'(sat_div(32'(div_i)));

   // >= rather than == so a smaller divisor loaded while frozen wraps at once.
   assign wrap    = en && !resync && (cnt_q >= div_q);
   assign rise    = wrap && !clk_q;
   assign clk_out = clk_q;

   always_comb begin
      // NOTE: every _d starts at its hold value so no path leaves it unassigned and infers a latch.
      cnt_d   = cnt_q;
      clk_d   = clk_q;
      div_d   = div_q;
      div_n_d = div_n_q;
      pend_d  = pend_q;
      if (resync) begin
         cnt_d  = CNT_ONE;
         clk_d  = 1'b0;
         pend_d = 1'b0;
         if (div_load)    div_d = div_sat;
         else if (pend_q) div_d = div_n_q;
      end else if (!en) begin
         if (div_load) begin
            div_d  = div_sat;
            pend_d = 1'b0;
         end
      end else if (wrap) begin
         cnt_d  = CNT_ONE;
         clk_d  = ~clk_q;
         pend_d = 1'b0;
         if (div_load)    div_d = div_sat;
         else if (pend_q) div_d = div_n_q;
      end else begin
         cnt_d = cnt_q + CNT_ONE;
         if (div_load) begin
            div_n_d = div_sat;
            pend_d  = 1'b1;
         end
      end
   end

   always_ff @(posedge sysclk or posedge reset) begin
      if (reset) begin
         cnt_q   <= CNT_ONE;
         div_q   <= DIV_RST;
         div_n_q <= DIV_RST;
         pend_q  <= 1'b0;
         clk_q   <= 1'b0;
      end else begin
         // NOTE: non-blocking updates so every flop samples the pre-edge values together.
         cnt_q   <= cnt_d;
         div_q   <= div_d;
         div_n_q <= div_n_d;
         pend_q  <= pend_d;
         clk_q   <= clk_d;
      end
   end

endmodule

// File: rtl/baud_rate_gen.sv
// UART baud generator top: prescaler plus oversample-phase counter and
// registered tick_os / tick_bit pulses.
module baud_rate_gen
   import baud_pkg::*;
#(
   parameter int DIV_W       = BAUD_DIV_W,
   parameter int DEFAULT_DIV = BAUD_DEFAULT_DIV,
   parameter int OVERSAMPLE  = BAUD_OVERSAMPLE
) (
   input logic            sysclk,
   input logic            reset,
   baud_rate_gen_if.slave bus
);

   localparam int              PH_W    = $clog2(OVERSAMPLE);
   localparam logic [PH_W-1:0] PH_LAST = PH_W'(OVERSAMPLE - 1);
   localparam logic [PH_W-1:0] PH_ONE  = PH_W'(1);

   logic            rise;
   logic [PH_W-1:0] os_phase_q, os_phase_d;
   logic            tick_os_q, tick_os_d;
   logic            tick_bit_q, tick_bit_d;

   baud_prescaler #(
      .DIV_W       (DIV_W),
      .DEFAULT_DIV (DEFAULT_DIV)
   ) u_prescaler (
      .sysclk   (sysclk),
      .reset    (reset),
      .en       (bus.en),
      .div_i    (bus.div_i),
      .div_load (bus.div_load),
      .resync   (bus.resync),
      .clk_out  (bus.clk_out),
      .rise     (rise)
   );

   // rise is already suppressed by en=0 and resync, so ticks drop to 0 there.
   always_comb begin
      os_phase_d = os_phase_q;
      tick_os_d  = 1'b0;
      tick_bit_d = 1'b0;
      if (bus.resync) begin
         os_phase_d = '0;
      end else if (rise) begin
         tick_os_d  = 1'b1;
         tick_bit_d = (os_phase_q == PH_LAST);
         os_phase_d = (os_phase_q == PH_LAST) ? '0 : os_phase_q + PH_ONE;
      end
   end

   always_ff @(posedge sysclk or posedge reset) begin
      if (reset) begin
         os_phase_q <= '0;
         tick_os_q  <= 1'b0;
         tick_bit_q <= 1'b0;
      end else begin
         os_phase_q <= os_phase_d;
         tick_os_q  <= tick_os_d;
         tick_bit_q <= tick_bit_d;
      end
   end

   assign bus.os_phase = os_phase_q;
   assign bus.tick_os  = tick_os_q;
   assign bus.tick_bit = tick_bit_q;

endmodule

// File: tb/tb_baud_rate_gen.sv
// Self-checking bench for baud_rate_gen: expected tick_os events are queued
// when stimulus is driven and matched as the DUT produces them.
module tb_baud_rate_gen;

   localparam int DIV_W = 10;
   localparam int DEF   = 163;
   localparam int OS    = 16;
   localparam int PH_W  = 4;

   typedef struct {
      int              cyc;
      logic            bit_t;
      logic [PH_W-1:0] ph;
   } exp_t;

   logic sysclk = 1'b0;
   logic reset;
   int   errors = 0;
   int   checks = 0;
   int   edge_n = 0;
   exp_t exp_q[$];

   baud_rate_gen_if #(.DIV_W(DIV_W), .OVERSAMPLE(OS)) bus ();

   baud_rate_gen #(
      .DIV_W       (DIV_W),
      .DEFAULT_DIV (DEF),
      .OVERSAMPLE  (OS)
   ) dut (
      .sysclk (sysclk),
      .reset  (reset),
      .bus    (bus)
   );

   always #5 sysclk = ~sysclk;

   // j is the index of the tick counted from the point where os_phase was 0.
   function automatic void push_tick(int cyc, int j);
      exp_t e;
      e.cyc   = cyc;
      e.ph    = PH_W'((j + 1) % OS);
      e.bit_t = ((j % OS) == OS - 1);
      exp_q.push_back(e);
   endfunction

   task automatic step();
      exp_t e;
      @(posedge sysclk);
      #1;
      edge_n++;
      if (bus.tick_os === 1'b1) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_tick edge=%0d got tick_os=1 want 0", edge_n);
         end else begin
            e = exp_q.pop_front();
            if (edge_n !== e.cyc) begin
               errors++;
               $display("FAIL tick_edge got edge=%0d want edge=%0d", edge_n, e.cyc);
            end
            checks++;
            if ({bus.tick_bit, bus.os_phase} !== {e.bit_t, e.ph}) begin
               errors++;
               $display("FAIL tick_state edge=%0d got bit=%b phase=%0d want bit=%b phase=%0d",
                        edge_n, bus.tick_bit, bus.os_phase, e.bit_t, e.ph);
            end
         end
      end else begin
         checks++;
         if (bus.tick_bit !== 1'b0) begin
            errors++;
            $display("FAIL bit_without_os edge=%0d got tick_bit=%b want 0", edge_n, bus.tick_bit);
         end
         if (exp_q.size() != 0 && exp_q[0].cyc <= edge_n) begin
            e = exp_q.pop_front();
            checks++;
            errors++;
            $display("FAIL missing_tick edge=%0d got tick_os=%b want 1 (due edge %0d)",
                     edge_n, bus.tick_os, e.cyc);
         end
      end
   endtask

   task automatic run_to(int target);
      while (edge_n < target) step();
   endtask

   task automatic leftover(string name);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL %s_leftover got %0d pending ticks want 0", name, exp_q.size());
      end
   endtask

   task automatic do_reset(logic en_v);
      reset        = 1'b1;
      bus.en       = 1'b0;
      bus.div_load = 1'b0;
      bus.resync   = 1'b0;
      bus.div_i    = '0;
      exp_q.delete();
      repeat (2) @(negedge sysclk);
      bus.en = en_v;
      reset  = 1'b0;
      edge_n = 0;
   endtask

   task automatic test_reset();
      repeat (3) @(negedge sysclk);
      checks++;
      if (bus.clk_out !== 1'b0) begin
         errors++; $display("FAIL reset_clk_out got %b want 0", bus.clk_out);
      end
      checks++;
      if (bus.tick_os !== 1'b0) begin
         errors++; $display("FAIL reset_tick_os got %b want 0", bus.tick_os);
      end
      checks++;
      if (bus.tick_bit !== 1'b0) begin
         errors++; $display("FAIL reset_tick_bit got %b want 0", bus.tick_bit);
      end
      checks++;
      if (bus.os_phase !== 4'd0) begin
         errors++; $display("FAIL reset_os_phase got %0d want 0", bus.os_phase);
      end
   endtask

   task automatic test_default();
      do_reset(1'b1);
      for (int j = 0; j < 32; j++) push_tick(DEF + 2 * DEF * j, j);
      run_to(DEF - 1);
      checks++;
      if (bus.clk_out !== 1'b0) begin
         errors++; $display("FAIL default_clk_pre got %b want 0", bus.clk_out);
      end
      step();
      checks++;
      if (bus.clk_out !== 1'b1) begin
         errors++; $display("FAIL default_clk_rise got %b want 1", bus.clk_out);
      end
      run_to(2 * DEF);
      checks++;
      if (bus.clk_out !== 1'b0) begin
         errors++; $display("FAIL default_clk_fall got %b want 0", bus.clk_out);
      end
      run_to(10300);
      leftover("default");
   endtask

   task automatic test_div_load();
      do_reset(1'b1);
      run_to(49);
      bus.div_i    = 10'd4;
      bus.div_load = 1'b1;
      for (int j = 0; j <= 20; j++) push_tick(DEF + 8 * j, j);
      step();
      bus.div_load = 1'b0;
      run_to(166);
      checks++;
      if (bus.clk_out !== 1'b1) begin
         errors++; $display("FAIL load_clk_166 got %b want 1", bus.clk_out);
      end
      step();
      checks++;
      if (bus.clk_out !== 1'b0) begin
         errors++; $display("FAIL load_clk_167 got %b want 0", bus.clk_out);
      end
      run_to(330);
      leftover("div_load");
   endtask

   task automatic test_div_zero();
      do_reset(1'b0);
      bus.div_i    = 10'd0;
      bus.div_load = 1'b1;
      step();
      bus.div_load = 1'b0;
      step();
      step();
      checks++;
      if (bus.clk_out !== 1'b0) begin
         errors++; $display("FAIL zero_frozen_clk got %b want 0", bus.clk_out);
      end
      bus.en = 1'b1;
      for (int j = 0; j <= 33; j++) push_tick(4 + 2 * j, j);
      step();
      checks++;
      if (bus.clk_out !== 1'b1) begin
         errors++; $display("FAIL zero_clk_4 got %b want 1", bus.clk_out);
      end
      step();
      checks++;
      if (bus.clk_out !== 1'b0) begin
         errors++; $display("FAIL zero_clk_5 got %b want 0", bus.clk_out);
      end
      run_to(70);
      leftover("div_zero");
   endtask

   task automatic test_enable();
      do_reset(1'b1);
      push_tick(163, 0);
      push_tick(489, 1);
      run_to(499);
      bus.en = 1'b0;
      push_tick(825, 2);
      push_tick(1151, 3);
      repeat (5) step();
      checks++;
      if ({bus.clk_out, bus.os_phase} !== {1'b1, 4'd2}) begin
         errors++;
         $display("FAIL enable_frozen got clk=%b phase=%0d want clk=1 phase=2",
                  bus.clk_out, bus.os_phase);
      end
      repeat (5) step();
      bus.en = 1'b1;
      run_to(661);
      checks++;
      if (bus.clk_out !== 1'b1) begin
         errors++; $display("FAIL enable_clk_661 got %b want 1", bus.clk_out);
      end
      step();
      checks++;
      if (bus.clk_out !== 1'b0) begin
         errors++; $display("FAIL enable_clk_662 got %b want 0", bus.clk_out);
      end
      run_to(1160);
      leftover("enable");
   endtask

   task automatic test_resync();
      do_reset(1'b0);
      bus.div_i    = 10'd4;
      bus.div_load = 1'b1;
      step();
      bus.div_load = 1'b0;
      bus.en       = 1'b1;
      for (int j = 0; j <= 6; j++) push_tick(5 + 8 * j, j);
      run_to(53);
      bus.resync = 1'b1;
      for (int j = 0; j <= 16; j++) push_tick(58 + 8 * j, j);
      step();
      bus.resync = 1'b0;
      checks++;
      if ({bus.clk_out, bus.os_phase, bus.tick_os} !== {1'b0, 4'd0, 1'b0}) begin
         errors++;
         $display("FAIL resync_state got clk=%b phase=%0d tick=%b want clk=0 phase=0 tick=0",
                  bus.clk_out, bus.os_phase, bus.tick_os);
      end
      run_to(57);
      checks++;
      if (bus.clk_out !== 1'b0) begin
         errors++; $display("FAIL resync_clk_57 got %b want 0", bus.clk_out);
      end
      run_to(190);
      leftover("resync");
   endtask

   task automatic test_back_to_back();
      do_reset(1'b1);
      run_to(9);
      bus.div_i    = 10'd5;
      bus.div_load = 1'b1;
      step();
      bus.div_i = 10'd3;
      push_tick(163, 0);
      push_tick(169, 1);
      step();
      bus.div_load = 1'b0;
      run_to(166);
      checks++;
      if (bus.clk_out !== 1'b0) begin
         errors++; $display("FAIL b2b_clk_166 got %b want 0", bus.clk_out);
      end
      run_to(168);
      bus.div_i    = 10'd2;
      bus.div_load = 1'b1;
      for (int j = 2; j <= 6; j++) push_tick(173 + 4 * (j - 2), j);
      step();
      bus.div_load = 1'b0;
      run_to(171);
      checks++;
      if (bus.clk_out !== 1'b0) begin
         errors++; $display("FAIL bypass_clk_171 got %b want 0", bus.clk_out);
      end
      run_to(190);
      leftover("back_to_back");
   endtask

   task automatic test_async_reset();
      do_reset(1'b0);
      bus.div_i    = 10'd7;
      bus.div_load = 1'b1;
      step();
      bus.div_load = 1'b0;
      bus.en       = 1'b1;
      for (int j = 0; j <= 2; j++) push_tick(8 + 14 * j, j);
      run_to(40);
      checks++;
      if ({bus.clk_out, bus.os_phase} !== {1'b1, 4'd3}) begin
         errors++;
         $display("FAIL pre_reset_state got clk=%b phase=%0d want clk=1 phase=3",
                  bus.clk_out, bus.os_phase);
      end
      leftover("pre_reset");
      @(posedge sysclk);
      #3;
      reset = 1'b1;
      #1;
      checks++;
      if ({bus.clk_out, bus.os_phase, bus.tick_os, bus.tick_bit} !== {1'b0, 4'd0, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL async_reset_outputs got clk=%b phase=%0d os=%b bit=%b want all 0",
                  bus.clk_out, bus.os_phase, bus.tick_os, bus.tick_bit);
      end
      do_reset(1'b1);
      push_tick(DEF, 0);
      push_tick(3 * DEF, 1);
      run_to(DEF);
      checks++;
      if (bus.clk_out !== 1'b1) begin
         errors++; $display("FAIL post_reset_clk got %b want 1", bus.clk_out);
      end
      run_to(500);
      leftover("post_reset");
   endtask

   initial begin
      reset        = 1'b1;
      bus.en       = 1'b0;
      bus.div_i    = '0;
      bus.div_load = 1'b0;
      bus.resync   = 1'b0;
      test_reset();
      test_default();
      test_div_load();
      test_div_zero();
      test_enable();
      test_resync();
      test_back_to_back();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
